fluxo_dados_param: RTL

//  Parametrised datapath for the memory-sequence game: play memory, address and limit

---
 rtl/fluxo_dados_param_pkg.sv | 20 ++
 rtl/fluxo_dados_param_if.sv | 45 ++++
 rtl/fluxo_dados_param_ram.sv | 40 ++++
 rtl/fluxo_dados_param.sv | 103 ++++++++++
 4 files changed

// File: rtl/fluxo_dados_param_pkg.sv
// Shared definitions for the memory-game datapath.
// Holds the default sizes used by the datapath, the controller and the top level,
// plus a small helper that classifies a play as exactly one-hot.
package fluxo_dados_param_pkg;

    localparam int NBOT_DEF    = 4;     // number of buttons / data width
    localparam int ADDR_W_DEF  = 4;     // sequence depth = 2**ADDR_W_DEF
    localparam int TIMEOUT_DEF = 4000;  // cycles allowed per play

    // The argument is zero-extended by the caller. This works for up to 32 buttons.
    function automatic logic is_one_hot(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/fluxo_dados_param_if.sv
// Bundle between the game controller (master) and the datapath (slave).
//  master drives: zeraE/contaE, zeraL/contaL, zeraR/registraR, zeraT/contaT,
//                 escreveM, botoes
//  slave drives:  comparator flags, jogada_feita, timeout and debug buses
// All signals are plain levels sampled on the rising clock edge. There is no
// valid/ready handshake. Each control is a single-cycle command and is honoured
// in every cycle in which it is high.
interface fluxo_dados_param_if #(
    parameter int NBOT   = 4,
    parameter int ADDR_W = 4
);
    logic              zeraE, contaE;
    logic              zeraL, contaL;
    logic              zeraR, registraR;
    logic              zeraT, contaT;
    logic              escreveM;
    logic [NBOT-1:0]   botoes;

    logic              jogadaIgualMemoria;
    logic              jogada_valida;
    logic              fimE, fimL;
    logic              enderecoIgualLimite;
    logic              enderecoMenorLimite;
    logic              jogada_feita;
    logic              timeout;
    logic              db_tem_jogada;
    logic [ADDR_W-1:0] db_contagem, db_limite;
    logic [NBOT-1:0]   db_memoria, db_jogada;

    modport master (
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               escreveM, botoes,
        input  jogadaIgualMemoria, jogada_valida, fimE, fimL, enderecoIgualLimite,
               enderecoMenorLimite, jogada_feita, timeout, db_tem_jogada,
               db_contagem, db_limite, db_memoria, db_jogada
    );

    modport slave (
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               escreveM, botoes,
        output jogadaIgualMemoria, jogada_valida, fimE, fimL, enderecoIgualLimite,
               enderecoMenorLimite, jogada_feita, timeout, db_tem_jogada,
               db_contagem, db_limite, db_memoria, db_jogada
    );
endinterface

// File: rtl/fluxo_dados_param_ram.sv
// Synchronous sequence RAM, 2**AW words of W bits, with a registered read port.
//  clk_i    clock
//  rst_i    async active-high reset. It clears the read register only. The array keeps its contents.
//  we_i     write RAM[addr_i] <= wdata_i
//  addr_i   read/write address
//  wdata_i  write data
//  rdata_o  registered read data, write-first on a write cycle
module fluxo_dados_param_ram #(
    parameter int W  = 4,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rdata_q, rdata_d;

    // The array has no reset, so it can map onto block/distributed RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // On a write, forward the new word so the next cycle already shows it.
    always_comb begin
        rdata_d = we_i ? wdata_i : mem_q[addr_i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fluxo_dados_param.sv
// Parametrised datapath for the memory-sequence game.
// Contents: address (E) and limit (L) counters, the play register (R), the sequence
// RAM, the comparators, an edge detector on "any button" and a saturating timeout
// counter (T).
//  clock  rising-edge clock
//  reset  async active-high. It clears every register except the RAM array.
//  bus    fluxo_dados_param_if.slave. It carries the controller commands, the raw
//         buttons, the status flags and the debug values.
// The RAM array has no reset and holds undefined data until the controller writes it
// through escreveM.
module fluxo_dados_param
    import fluxo_dados_param_pkg::*;
#(
    parameter int NBOT    = NBOT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    fluxo_dados_param_if.slave bus
);
    localparam int                TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]     T_MAX    = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [NBOT-1:0]   jogada_q, jogada_d;
    logic [TW-1:0]     tempo_q, tempo_d;
    logic              prev_q, prev_d;
    logic              tem_jogada;
    logic [NBOT-1:0]   memoria_out;

    assign tem_jogada = |bus.botoes;

    always_comb begin
        endereco_d = endereco_q;
        if (bus.zeraE)       endereco_d = '0;
        else if (bus.contaE) endereco_d = endereco_q + ADDR_W'(1);  // wraps at DEPTH-1

        limite_d = limite_q;
        if (bus.zeraL)       limite_d = '0;
        else if (bus.contaL) limite_d = limite_q + ADDR_W'(1);

        jogada_d = jogada_q;
        if (bus.zeraR)          jogada_d = '0;
        else if (bus.registraR) jogada_d = bus.botoes;

        // Dropping contaT also restarts the count, so each play window is measured
        // from the cycle in which counting resumes.
        tempo_d = tempo_q;
        if (bus.zeraT || !bus.contaT) tempo_d = '0;
        else if (tempo_q != T_MAX)    tempo_d = tempo_q + TW'(1);

        prev_d = tem_jogada;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco_q <= '0;
            limite_q   <= '0;
            jogada_q   <= '0;
            tempo_q    <= '0;
            prev_q     <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            jogada_q   <= jogada_d;
            tempo_q    <= tempo_d;
            prev_q     <= prev_d;
        end
    end

    // The write uses the registered address, so escreveM together with zeraE
    // targets the address held before the clear.
    fluxo_dados_param_ram #(
        .W  (NBOT),
        .AW (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (bus.escreveM),
        .addr_i  (endereco_q),
        .wdata_i (jogada_q),
        .rdata_o (memoria_out)
    );

    assign bus.jogadaIgualMemoria  = (memoria_out == jogada_q);
    assign bus.jogada_valida       = is_one_hot(32'(jogada_q));
    assign bus.fimE                = (endereco_q == ADDR_MAX);
    assign bus.fimL                = (limite_q == ADDR_MAX);
    assign bus.enderecoIgualLimite = (endereco_q == limite_q);
    assign bus.enderecoMenorLimite = (endereco_q < limite_q);
    // A second button pressed while the first is still held keeps tem_jogada high,
    // so it produces no further pulse.
    assign bus.jogada_feita        = tem_jogada & ~prev_q;
    assign bus.timeout             = (tempo_q == T_MAX);
    assign bus.db_tem_jogada       = tem_jogada;
    assign bus.db_contagem         = endereco_q;
    assign bus.db_limite           = limite_q;
    assign bus.db_memoria          = memoria_out;
    assign bus.db_jogada           = jogada_q;
endmodule
